// File: rtl/done_led_sched.sv
// done_led_sched: round-robin scheduler that plays per-requester blink patterns
// on the STARTUPE3 DONE LED, with an LED-off gap after each pattern.
module done_led_sched #(
   parameter int NREQ          = 4,
   parameter int PATTERN_WIDTH = 16,
   parameter int TICK_DIV      = 3125000,
   parameter int GAP_TICKS     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*PATTERN_WIDTH-1:0] pattern,
   input  logic                          idle_on,
   output logic [NREQ-1:0]               ack,
   output logic                          busy,
   output logic                          led,
   output logic                          usrdoneo,
   output logic                          usrdonets
);
   localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int IW = PATTERN_WIDTH > 1 ? $clog2(PATTERN_WIDTH) : 1;
   localparam int XW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
   localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2;

   logic [1:0]               state;
   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic [XW-1:0]            gcnt;
   logic [PATTERN_WIDTH-1:0] pat, gpat;
   logic [GW-1:0]            last_grant, grant;
   logic                     found, tick;

   // lowest k wins: scan from the far end so the nearest hit overwrites
   always_comb begin
      grant = last_grant;
      found = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % NREQ]) begin
            grant = GW'((int'(last_grant) + k) % NREQ);
            found = 1'b1;
         end
      end
      gpat = pattern[int'(grant)*PATTERN_WIDTH +: PATTERN_WIDTH];
   end

   assign tick      = (state != IDLE) && (cnt == CW'(TICK_DIV - 1));
   assign usrdoneo  = 1'b0;
   assign usrdonets = led;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         gcnt       <= '0;
         pat        <= '0;
         last_grant <= GW'(NREQ - 1);
         ack        <= '0;
         busy       <= 1'b0;
         led        <= 1'b0;
      end else begin
         ack <= '0;
         cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: begin
               led  <= idle_on;
               busy <= 1'b0;
               if (found) begin
                  state      <= PLAY;
                  pat        <= gpat;
                  last_grant <= grant;
                  ack        <= NREQ'(1) << grant;
                  idx        <= IW'(PATTERN_WIDTH - 1);
                  gcnt       <= '0;
                  busy       <= 1'b1;
                  led        <= gpat[PATTERN_WIDTH-1];
               end
            end
            PLAY: begin
               if (tick) begin
                  if (idx == '0) begin
                     if (GAP_TICKS == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        led   <= idle_on;
                     end else begin
                        state <= GAP;
                        gcnt  <= '0;
                        led   <= 1'b0;
                     end
                  end else begin
                     idx <= idx - 1'b1;
                     led <= pat[idx - 1'b1];
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (gcnt == XW'(GAP_TICKS - 1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     led   <= idle_on;
                  end else begin
                     gcnt <= gcnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_done_led_sched.sv
// tb_done_led_sched: random and directed stimulus on two schedulers (gap 2 and gap 0),
// checked every cycle against a timeline model of what the LED must show.
module tb_done_led_sched;
   localparam int N = 4, PW = 8, TD = 4;

   logic          clk = 1'b0, rst = 1'b1, idle_on = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*PW-1:0] pattern = '0;
   logic [N-1:0]  ack0, ack1;
   logic          busy0, led0, udo0, udt0, busy1, led1, udo1, udt1;
   int            vectors = 0, errors = 0;

   always #5 clk = ~clk;

   done_led_sched #(.NREQ(N), .PATTERN_WIDTH(PW), .TICK_DIV(TD), .GAP_TICKS(2)) u0 (
      .clk(clk), .rst(rst), .req(req), .pattern(pattern), .idle_on(idle_on),
      .ack(ack0), .busy(busy0), .led(led0), .usrdoneo(udo0), .usrdonets(udt0));
   done_led_sched #(.NREQ(N), .PATTERN_WIDTH(PW), .TICK_DIV(TD), .GAP_TICKS(0)) u1 (
      .clk(clk), .rst(rst), .req(req), .pattern(pattern), .idle_on(idle_on),
      .ack(ack1), .busy(busy1), .led(led1), .usrdoneo(udo1), .usrdonets(udt1));

   // model: a grant starts a timeline of (PW+gap)*TD cycles; position within it gives the LED
   int           gap [2] = '{2, 0};
   bit           play [2];
   int           pos [2];
   int           last [2];
   logic [PW-1:0] p [2];
   logic [N-1:0] eack [2];
   logic         ebusy [2], eled [2];
   bit           live = 1'b0;

   always @(posedge clk) begin
      int g;
      for (int m = 0; m < 2; m++) begin
         eack[m] = '0;
         if (rst) begin
            play[m] = 1'b0; last[m] = N - 1; ebusy[m] = 1'b0; eled[m] = 1'b0;
         end else if (play[m]) begin
            pos[m]++;
            if (pos[m] == (PW + gap[m]) * TD) begin
               play[m] = 1'b0; ebusy[m] = 1'b0; eled[m] = idle_on;
            end else begin
               eled[m] = pos[m] < PW * TD ? p[m][PW - 1 - pos[m] / TD] : 1'b0;
            end
         end else begin
            ebusy[m] = 1'b0; eled[m] = idle_on; g = -1;
            for (int k = 1; k <= N; k++)
               if (g < 0 && req[(last[m] + k) % N]) g = (last[m] + k) % N;
            if (g >= 0) begin
               play[m] = 1'b1; pos[m] = 0; last[m] = g;
               p[m] = pattern[g*PW +: PW];
               eack[m] = N'(1) << g; ebusy[m] = 1'b1; eled[m] = p[m][PW-1];
            end
         end
      end
      if (rst) live = 1'b1;
   end

   task automatic chk(input string n, input logic [N+3:0] a, input logic [N+3:0] e);
      vectors++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0t got {ack,busy,led,usrdonets,usrdoneo}=%b want=%b", n, $time, a, e);
      end
   endtask

   task automatic lit(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (live) begin
         chk("gap2", {ack0, busy0, led0, udt0, udo0}, {eack[0], ebusy[0], eled[0], eled[0], 1'b0});
         chk("gap0", {ack1, busy1, led1, udt1, udo1}, {eack[1], ebusy[1], eled[1], eled[1], 1'b0});
      end
   end

   task automatic do_reset();
      rst = 1'b1; req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic grant_next(input logic [N-1:0] r, input string nm, input int want);
      int t = 0;
      req = r;
      do begin @(negedge clk); t++; end while (ack0 == '0 && t < 200);
      lit(nm, 64'(ack0), 64'(N'(1) << want));
   endtask

   initial begin
      logic [39:0] seq;
      int bc, lc, t;
      repeat (3) @(negedge clk);
      lit("rst_led", 64'(led0), 64'd0);
      lit("rst_busy", 64'(busy0), 64'd0);
      lit("rst_ack", 64'(ack0), 64'd0);
      rst = 1'b0; idle_on = 1'b1;
      @(negedge clk);
      lit("idle_on", 64'(led0), 64'd1);

      pattern[7:0] = 8'b1010_0011;
      grant_next(4'b0001, "single_ack", 0);
      req = '0; pattern[7:0] = 8'hFF;
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         seq[39-i] = led0;
         if (busy0) bc++;
         @(negedge clk);
      end
      lit("single_seq", 64'(seq), 64'hF0F000FF00);
      lit("single_busy", 64'(bc), 64'd40);
      lit("single_end_busy", 64'(busy0), 64'd0);
      lit("single_end_led", 64'(led0), 64'd1);

      do_reset();
      grant_next(4'b1111, "rr0", 0);
      grant_next(4'b1111, "rr1", 1);
      grant_next(4'b1111, "rr2", 2);
      grant_next(4'b1111, "rr3", 3);
      grant_next(4'b1111, "rr4", 0);

      do_reset();
      for (int i = 0; i < 4; i++) grant_next(4'b1111, "wrap_pre", i);
      grant_next(4'b1001, "wrap0", 0);
      grant_next(4'b1001, "wrap3", 3);

      req = 4'b1111;
      t = 0;
      while (busy1 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      while (busy1 !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      lc = 0;
      while (busy1 !== 1'b1 && lc < 10) begin @(negedge clk); lc++; end
      lit("zero_gap_idle", 64'(lc), 64'd1);

      do_reset();
      pattern[23:16] = 8'hFF;
      grant_next(4'b0100, "pre_abort", 2);
      req = '0;
      repeat (16) @(negedge clk);
      lit("mid_play_led", 64'(led0), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lit("abort_led", 64'(led0), 64'd0);
      lit("abort_busy", 64'(busy0), 64'd0);
      lit("abort_ack", 64'(ack0), 64'd0);
      lit("abort_ts", 64'(udt0), 64'd0);
      grant_next(4'b1111, "after_abort", 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         if ($urandom_range(0, 7) == 0) pattern = {$urandom};
         if ($urandom_range(0, 15) == 0) idle_on = 1'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      rst = 1'b0; req = '0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/done_led_sched.md
DONE_LED_SCHED -- requirements
Module: done_led_sched

Interface
REQ-001 Parameter NREQ, default 4: number of pattern requesters.
REQ-002 Parameter PATTERN_WIDTH, default 16: bits per blink pattern.
REQ-003 Parameter TICK_DIV, default 3125000: clk cycles per pattern bit (62.5 ms at 50 MHz CFGMCLK).
REQ-004 Parameter GAP_TICKS, default 8: LED-off ticks inserted after each pattern; legal range 0..255.
REQ-005 clk  input  1  single clock for all logic (BUFG'd 50 MHz CFGMCLK); one clock, no other clock domains.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req  input  NREQ  per-requester level request to play its pattern.
REQ-008 pattern  input  NREQ*PATTERN_WIDTH  requester i pattern in bits [i*PATTERN_WIDTH +: PATTERN_WIDTH]; 1 = LED on.
REQ-009 idle_on  input  1  LED state while IDLE.
REQ-010 ack  output  NREQ  one-cycle pulse on bit i when requester i's pattern is latched.
REQ-011 busy  output  1  high in PLAY or GAP.
REQ-012 led  output  1  current LED state (1 = on).
REQ-013 usrdoneo  output  1  to STARTUPE3 USRDONEO; constant 0.
REQ-014 usrdonets  output  1  to STARTUPE3 USRDONETS; equals led (tri-state = LED on, drive low = LED off).

Function
REQ-015 States IDLE, PLAY, GAP; all outputs registered except usrdoneo.
REQ-016 IDLE: led = idle_on; when any req bit high, grant one requester by round-robin, latch its pattern, pulse ack[grant] next cycle, clear tick counter, set bit index = PATTERN_WIDTH-1, enter PLAY.
REQ-017 Round-robin: search starts at index (last_grant+1) mod NREQ, ascending with wrap; last_grant resets to NREQ-1 so requester 0 wins first.
REQ-018 Tick counter counts 0..TICK_DIV-1, wraps to 0; tick = 1 for the cycle where counter = TICK_DIV-1; counter runs only in PLAY/GAP.
REQ-019 PLAY: led = latched_pattern[bit index], MSB first; each bit lasts exactly TICK_DIV cycles; on tick with index 0 -> GAP (or IDLE if GAP_TICKS = 0), else index decrements.
REQ-020 GAP: led = 0 for exactly GAP_TICKS ticks, then IDLE.
REQ-021 First cycle of IDLE after GAP may grant immediately; a req still held is re-arbitrated (level semantics); no request is queued internally.
REQ-022 Changes to req/pattern during PLAY/GAP have no effect on the pattern being played.
REQ-023 Simultaneous requests: exactly one ack bit per grant; ack never asserted outside the IDLE->PLAY transition.
REQ-024 Counter and index widths: $clog2 of their ranges, minimum 1 bit; no overflow at wrap.

Reset
REQ-025 rst high on a rising clk edge forces, in any state: state IDLE, tick counter 0, bit index 0, latched pattern 0, last_grant NREQ-1, ack 0, busy 0, led 0, usrdonets 0.
REQ-026 led follows idle_on starting the first cycle after rst deasserts.
REQ-027 rst asserted mid-PLAY or mid-GAP aborts the pattern with no ack and no further LED activity from it.

Verification (NREQ=4, PATTERN_WIDTH=8, TICK_DIV=4, GAP_TICKS=2)
REQ-028 Single: req=0001, pattern0=8'b1010_0011 -> ack=0001 one cycle; led = 1,0,1,0,0,0,1,1 each 4 cycles, then 0 for 8 cycles, then idle_on; busy high 40 cycles.
REQ-029 Contention: req=1111 held -> grant order 0,1,2,3,0; each ack a single-cycle pulse, never two bits set.
REQ-030 Wrap: after grant to 3, req=1001 -> next grant 0; then req=1001 -> next grant 3.
REQ-031 Zero gap (GAP_TICKS=0): held req -> PLAY of next pattern begins 1 cycle after last bit ends (IDLE lasts 1 cycle).
REQ-032 Reset mid-PLAY at bit 3 -> next cycle led=0, busy=0, usrdonets=0, state IDLE; no ack; requester 0 wins next grant.
REQ-033 Pattern change during PLAY: pattern0 toggled to 8'hFF after ack -> played sequence unchanged; usrdoneo 0 and usrdonets == led in all cycles.
